// File: rtl/scr1_memif.sv
// Shared DMEM/IMEM interface types: command, width, response encodings and
// router port identifiers with their default region constants.
package scr1_memif;

   localparam int unsigned SCR1_DMEM_AWIDTH = 32;
   localparam int unsigned SCR1_DMEM_DWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   typedef enum logic [1:0] {
      SCR1_DMEM_PORT0     = 2'b00,
      SCR1_DMEM_PORT1     = 2'b01,
      SCR1_DMEM_PORT_HOLE = 2'b10
   } type_scr1_dmem_port_e;

   localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_PORT0_MASK_DFLT    = 32'hFFFF_0000;
   localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_PORT0_PATTERN_DFLT = 32'h0048_0000;
   localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_PORT1_MASK_DFLT    = 32'h0000_0000;
   localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_PORT1_PATTERN_DFLT = 32'h0000_0000;

endpackage : scr1_memif

// File: rtl/scr1_dmem_port_decode.sv
// Address-to-port decoder: port 0 region wins over port 1; anything else is a hole.
module scr1_dmem_port_decode
   import scr1_memif::*;
#(
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT0_ADDR_MASK    = SCR1_DMEM_PORT0_MASK_DFLT,
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT0_ADDR_PATTERN = SCR1_DMEM_PORT0_PATTERN_DFLT,
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_MASK    = SCR1_DMEM_PORT1_MASK_DFLT,
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_PATTERN = SCR1_DMEM_PORT1_PATTERN_DFLT
) (
   input  logic [SCR1_DMEM_AWIDTH-1:0] addr_i,
   output type_scr1_dmem_port_e        port_o
);

   always_comb begin
      port_o = SCR1_DMEM_PORT_HOLE;
      if ((addr_i & SCR1_PORT0_ADDR_MASK) == SCR1_PORT0_ADDR_PATTERN) begin
         port_o = SCR1_DMEM_PORT0;
      end else if ((addr_i & SCR1_PORT1_ADDR_MASK) == SCR1_PORT1_ADDR_PATTERN) begin
         port_o = SCR1_DMEM_PORT1;
      end
   end

endmodule : scr1_dmem_port_decode

// File: rtl/scr1_dmem_port_router.sv
// Routes the LSU DMEM master to TCM (port 0) or external (port 1) by address,
// tracking one outstanding transaction; unmapped addresses get a local error.
module scr1_dmem_port_router
   import scr1_memif::*;
#(
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT0_ADDR_MASK    = SCR1_DMEM_PORT0_MASK_DFLT,
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT0_ADDR_PATTERN = SCR1_DMEM_PORT0_PATTERN_DFLT,
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_MASK    = SCR1_DMEM_PORT1_MASK_DFLT,
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_PATTERN = SCR1_DMEM_PORT1_PATTERN_DFLT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        lsu2dmem_req_i,
   input  type_scr1_mem_cmd_e          lsu2dmem_cmd_i,
   input  type_scr1_mem_width_e        lsu2dmem_width_i,
   input  logic [SCR1_DMEM_AWIDTH-1:0] lsu2dmem_addr_i,
   input  logic [SCR1_DMEM_DWIDTH-1:0] lsu2dmem_wdata_i,
   output logic                        dmem2lsu_req_ack_o,
   output logic [SCR1_DMEM_DWIDTH-1:0] dmem2lsu_rdata_o,
   output type_scr1_mem_resp_e         dmem2lsu_resp_o,
   output logic                        port0_req_o,
   output type_scr1_mem_cmd_e          port0_cmd_o,
   output type_scr1_mem_width_e        port0_width_o,
   output logic [SCR1_DMEM_AWIDTH-1:0] port0_addr_o,
   output logic [SCR1_DMEM_DWIDTH-1:0] port0_wdata_o,
   input  logic                        port0_req_ack_i,
   input  logic [SCR1_DMEM_DWIDTH-1:0] port0_rdata_i,
   input  type_scr1_mem_resp_e         port0_resp_i,
   output logic                        port1_req_o,
   output type_scr1_mem_cmd_e          port1_cmd_o,
   output type_scr1_mem_width_e        port1_width_o,
   output logic [SCR1_DMEM_AWIDTH-1:0] port1_addr_o,
   output logic [SCR1_DMEM_DWIDTH-1:0] port1_wdata_o,
   input  logic                        port1_req_ack_i,
   input  logic [SCR1_DMEM_DWIDTH-1:0] port1_rdata_i,
   input  type_scr1_mem_resp_e         port1_resp_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_ERR  = 2'b10
   } state_e;

   state_e               state_q, state_d;
   type_scr1_dmem_port_e port_q, port_d;
   type_scr1_dmem_port_e sel;
   logic                 ack;

   scr1_dmem_port_decode #(
      .SCR1_PORT0_ADDR_MASK    (SCR1_PORT0_ADDR_MASK),
      .SCR1_PORT0_ADDR_PATTERN (SCR1_PORT0_ADDR_PATTERN),
      .SCR1_PORT1_ADDR_MASK    (SCR1_PORT1_ADDR_MASK),
      .SCR1_PORT1_ADDR_PATTERN (SCR1_PORT1_ADDR_PATTERN)
   ) i_decode (
      .addr_i (lsu2dmem_addr_i),
      .port_o (sel)
   );

   // Command fields go to both slaves; only the req strobe is steered.
   assign port0_cmd_o   = lsu2dmem_cmd_i;
   assign port0_width_o = lsu2dmem_width_i;
   assign port0_addr_o  = lsu2dmem_addr_i;
   assign port0_wdata_o = lsu2dmem_wdata_i;
   assign port1_cmd_o   = lsu2dmem_cmd_i;
   assign port1_width_o = lsu2dmem_width_i;
   assign port1_addr_o  = lsu2dmem_addr_i;
   assign port1_wdata_o = lsu2dmem_wdata_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         port_q  <= SCR1_DMEM_PORT0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      port_d             = port_q;
      ack                = 1'b0;
      port0_req_o        = 1'b0;
      port1_req_o        = 1'b0;
      dmem2lsu_resp_o    = SCR1_MEM_RESP_NOTRDY;
      dmem2lsu_rdata_o   = '0;
      case (state_q)
         ST_IDLE: begin
            port0_req_o = lsu2dmem_req_i & (sel == SCR1_DMEM_PORT0);
            port1_req_o = lsu2dmem_req_i & (sel == SCR1_DMEM_PORT1);
            case (sel)
               SCR1_DMEM_PORT0: ack = port0_req_ack_i;
               SCR1_DMEM_PORT1: ack = port1_req_ack_i;
               default:         ack = 1'b1;
            endcase
            if (lsu2dmem_req_i && ack) begin
               if (sel == SCR1_DMEM_PORT_HOLE) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_WAIT;
                  port_d  = sel;
               end
            end
         end
         ST_WAIT: begin
            if (port_q == SCR1_DMEM_PORT1) begin
               dmem2lsu_resp_o  = port1_resp_i;
               dmem2lsu_rdata_o = port1_rdata_i;
            end else begin
               dmem2lsu_resp_o  = port0_resp_i;
               dmem2lsu_rdata_o = port0_rdata_i;
            end
            if (dmem2lsu_resp_o == SCR1_MEM_RESP_RDY_OK || dmem2lsu_resp_o == SCR1_MEM_RESP_RDY_ER) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            dmem2lsu_resp_o = SCR1_MEM_RESP_RDY_ER;
            state_d         = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      dmem2lsu_req_ack_o = ack;
   end

`ifndef SYNTHESIS
   a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
      lsu2dmem_req_i |-> !$isunknown({port0_req_o, port1_req_o, dmem2lsu_req_ack_o, dmem2lsu_resp_o}));
   a_onehot_req: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({port0_req_o, port1_req_o}));
   a_port_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ST_WAIT && state_d == ST_WAIT) |=> $stable(port_q));
   // Responses seen while idle belong to no transaction and are dropped.
   a_idle_resp: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ST_IDLE) |-> (port0_resp_i == SCR1_MEM_RESP_NOTRDY && port1_resp_i == SCR1_MEM_RESP_NOTRDY))
      else $warning("stray port response dropped while idle");
`endif

endmodule : scr1_dmem_port_router

// File: tb/tb_scr1_dmem_port_router.sv
// Directed bench for the DMEM port router: routing, stalls, holes, foreign
// responses, back-to-back issue and mid-transaction reset.
module tb_scr1_dmem_port_router;
   import scr1_memif::*;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 req = 1'b0;
   type_scr1_mem_cmd_e   cmd = SCR1_MEM_CMD_RD;
   type_scr1_mem_width_e width = SCR1_MEM_WIDTH_WORD;
   logic [31:0]          addr = '0;
   logic [31:0]          wdata = '0;
   logic                 ack;
   logic [31:0]          rdata;
   type_scr1_mem_resp_e  resp;
   logic                 p0_req, p1_req;
   type_scr1_mem_cmd_e   p0_cmd, p1_cmd;
   type_scr1_mem_width_e p0_width, p1_width;
   logic [31:0]          p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic                 p0_ack = 1'b0, p1_ack = 1'b0;
   logic [31:0]          p0_rdata = '0, p1_rdata = '0;
   type_scr1_mem_resp_e  p0_resp = SCR1_MEM_RESP_NOTRDY, p1_resp = SCR1_MEM_RESP_NOTRDY;

   // Second instance with a narrowed port 1 region, so unmapped addresses exist.
   logic                 d2_ack;
   logic [31:0]          d2_rdata;
   type_scr1_mem_resp_e  d2_resp;
   logic                 d2_p0_req, d2_p1_req;
   type_scr1_mem_cmd_e   d2_p0_cmd, d2_p1_cmd;
   type_scr1_mem_width_e d2_p0_width, d2_p1_width;
   logic [31:0]          d2_p0_addr, d2_p1_addr, d2_p0_wdata, d2_p1_wdata;
   logic                 d2_sl_ack = 1'b0;
   logic [31:0]          d2_sl_rdata = '0;
   type_scr1_mem_resp_e  d2_sl_resp = SCR1_MEM_RESP_NOTRDY;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   scr1_dmem_port_router dut (
      .clk(clk), .rst_n(rst_n),
      .lsu2dmem_req_i(req), .lsu2dmem_cmd_i(cmd), .lsu2dmem_width_i(width),
      .lsu2dmem_addr_i(addr), .lsu2dmem_wdata_i(wdata),
      .dmem2lsu_req_ack_o(ack), .dmem2lsu_rdata_o(rdata), .dmem2lsu_resp_o(resp),
      .port0_req_o(p0_req), .port0_cmd_o(p0_cmd), .port0_width_o(p0_width),
      .port0_addr_o(p0_addr), .port0_wdata_o(p0_wdata),
      .port0_req_ack_i(p0_ack), .port0_rdata_i(p0_rdata), .port0_resp_i(p0_resp),
      .port1_req_o(p1_req), .port1_cmd_o(p1_cmd), .port1_width_o(p1_width),
      .port1_addr_o(p1_addr), .port1_wdata_o(p1_wdata),
      .port1_req_ack_i(p1_ack), .port1_rdata_i(p1_rdata), .port1_resp_i(p1_resp)
   );

   scr1_dmem_port_router #(
      .SCR1_PORT1_ADDR_MASK    (32'hF000_0000),
      .SCR1_PORT1_ADDR_PATTERN (32'h1000_0000)
   ) dut2 (
      .clk(clk), .rst_n(rst_n),
      .lsu2dmem_req_i(req), .lsu2dmem_cmd_i(cmd), .lsu2dmem_width_i(width),
      .lsu2dmem_addr_i(addr), .lsu2dmem_wdata_i(wdata),
      .dmem2lsu_req_ack_o(d2_ack), .dmem2lsu_rdata_o(d2_rdata), .dmem2lsu_resp_o(d2_resp),
      .port0_req_o(d2_p0_req), .port0_cmd_o(d2_p0_cmd), .port0_width_o(d2_p0_width),
      .port0_addr_o(d2_p0_addr), .port0_wdata_o(d2_p0_wdata),
      .port0_req_ack_i(d2_sl_ack), .port0_rdata_i(d2_sl_rdata), .port0_resp_i(d2_sl_resp),
      .port1_req_o(d2_p1_req), .port1_cmd_o(d2_p1_cmd), .port1_width_o(d2_p1_width),
      .port1_addr_o(d2_p1_addr), .port1_wdata_o(d2_p1_wdata),
      .port1_req_ack_i(d2_sl_ack), .port1_rdata_i(d2_sl_rdata), .port1_resp_i(d2_sl_resp)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) step();
      n_run++; if (p0_req !== 1'b0) begin n_fail++; $display("FAIL rst_p0_req: got %b want 0", p0_req); end
      n_run++; if (p1_req !== 1'b0) begin n_fail++; $display("FAIL rst_p1_req: got %b want 0", p1_req); end
      n_run++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
      n_run++; if (resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL rst_resp: got %0d want 0", resp); end
      n_run++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_port0_read;
      req = 1'b1; cmd = SCR1_MEM_CMD_RD; addr = 32'h0048_0010; p0_ack = 1'b1;
      #1;
      n_run++; if (p0_req !== 1'b1) begin n_fail++; $display("FAIL rd0_p0_req: got %b want 1", p0_req); end
      n_run++; if (p1_req !== 1'b0) begin n_fail++; $display("FAIL rd0_p1_req: got %b want 0", p1_req); end
      n_run++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd0_ack: got %b want 1", ack); end
      n_run++; if (p1_addr !== 32'h0048_0010) begin n_fail++; $display("FAIL rd0_bcast_addr: got %h want 00480010", p1_addr); end
      step();
      req = 1'b0; p0_ack = 1'b0;
      #1;
      n_run++; if (p0_req !== 1'b0) begin n_fail++; $display("FAIL rd0_p0_pulse: got %b want 0", p0_req); end
      n_run++; if (resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL rd0_wait_resp: got %0d want 0", resp); end
      step();
      step();
      p0_resp = SCR1_MEM_RESP_RDY_OK; p0_rdata = 32'hDEAD_BEEF;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_RDY_OK) begin n_fail++; $display("FAIL rd0_resp: got %0d want 1", resp); end
      n_run++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd0_rdata: got %h want deadbeef", rdata); end
      n_run++; if (p1_req !== 1'b0) begin n_fail++; $display("FAIL rd0_p1_quiet: got %b want 0", p1_req); end
      step();
      p0_resp = SCR1_MEM_RESP_NOTRDY; p0_rdata = '0;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL rd0_idle_resp: got %0d want 0", resp); end
   endtask

   task automatic test_port1_write_stall;
      req = 1'b1; cmd = SCR1_MEM_CMD_WR; addr = 32'h2000_0000; wdata = 32'h1234_5678; p1_ack = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_run++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr1_stall_ack[%0d]: got %b want 0", i, ack); end
         n_run++; if (p1_req !== 1'b1 || p0_req !== 1'b0) begin n_fail++; $display("FAIL wr1_stall_req[%0d]: got p0=%b p1=%b want p0=0 p1=1", i, p0_req, p1_req); end
         step();
      end
      p1_ack = 1'b1;
      #1;
      n_run++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr1_ack: got %b want 1", ack); end
      n_run++; if (p1_wdata !== 32'h1234_5678 || p1_cmd !== SCR1_MEM_CMD_WR) begin n_fail++; $display("FAIL wr1_fields: got %h/%0d want 12345678/1", p1_wdata, p1_cmd); end
      step();
      p1_ack = 1'b0;
      #1;
      n_run++; if (p1_req !== 1'b0 || ack !== 1'b0) begin n_fail++; $display("FAIL wr1_no_reissue: got req=%b ack=%b want 0/0", p1_req, ack); end
      req = 1'b0;
      step();
      p1_resp = SCR1_MEM_RESP_RDY_OK;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_RDY_OK) begin n_fail++; $display("FAIL wr1_resp: got %0d want 1", resp); end
      step();
      p1_resp = SCR1_MEM_RESP_NOTRDY;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL wr1_idle_resp: got %0d want 0", resp); end
   endtask

   task automatic test_hole;
      req = 1'b1; cmd = SCR1_MEM_CMD_RD; addr = 32'h3000_0000;
      #1;
      n_run++; if (d2_ack !== 1'b1) begin n_fail++; $display("FAIL hole_ack: got %b want 1", d2_ack); end
      n_run++; if (d2_p0_req !== 1'b0 || d2_p1_req !== 1'b0) begin n_fail++; $display("FAIL hole_req: got p0=%b p1=%b want 0/0", d2_p0_req, d2_p1_req); end
      step();
      req = 1'b0;
      #1;
      n_run++; if (d2_resp !== SCR1_MEM_RESP_RDY_ER) begin n_fail++; $display("FAIL hole_resp: got %0d want 2", d2_resp); end
      n_run++; if (d2_rdata !== 32'h0) begin n_fail++; $display("FAIL hole_rdata: got %h want 0", d2_rdata); end
      step();
      n_run++; if (d2_resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL hole_after: got %0d want 0", d2_resp); end
   endtask

   task automatic test_ignore_other_port;
      req = 1'b1; addr = 32'h0048_0100; p0_ack = 1'b1;
      step();
      req = 1'b0; p0_ack = 1'b0; p1_resp = SCR1_MEM_RESP_RDY_ER; p1_rdata = 32'hBAD0_BAD0;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_NOTRDY || rdata !== 32'h0) begin n_fail++; $display("FAIL ign_foreign: got %0d/%h want 0/0", resp, rdata); end
      step();
      p1_resp = SCR1_MEM_RESP_NOTRDY; p1_rdata = '0; p0_resp = SCR1_MEM_RESP_RDY_OK; p0_rdata = 32'h1111_2222;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_RDY_OK || rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL ign_own: got %0d/%h want 1/11112222", resp, rdata); end
      step();
      p0_resp = SCR1_MEM_RESP_NOTRDY; p0_rdata = '0;
   endtask

   task automatic test_back_to_back;
      req = 1'b1; addr = 32'h0048_0200; p0_ack = 1'b1;
      step();
      p0_resp = SCR1_MEM_RESP_RDY_ER;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_RDY_ER) begin n_fail++; $display("FAIL b2b_err_fwd: got %0d want 2", resp); end
      n_run++; if (ack !== 1'b0 || p0_req !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got ack=%b req=%b want 0/0", ack, p0_req); end
      step();
      p0_resp = SCR1_MEM_RESP_NOTRDY;
      #1;
      n_run++; if (ack !== 1'b1 || p0_req !== 1'b1) begin n_fail++; $display("FAIL b2b_next_accept: got ack=%b req=%b want 1/1", ack, p0_req); end
      step();
      req = 1'b0; p0_ack = 1'b0;
      #1;
      n_run++; if (ack !== 1'b0 || resp !== SCR1_MEM_RESP_NOTRDY) begin n_fail++; $display("FAIL b2b_wait: got ack=%b resp=%0d want 0/0", ack, resp); end
      p0_resp = SCR1_MEM_RESP_RDY_OK;
      step();
      p0_resp = SCR1_MEM_RESP_NOTRDY;
   endtask

   task automatic test_reset_mid_wait;
      req = 1'b1; addr = 32'h0048_0300; p0_ack = 1'b1;
      step();
      req = 1'b0; p0_ack = 1'b0;
      rst_n = 1'b0;
      #1;
      n_run++; if (p0_req !== 1'b0 || p1_req !== 1'b0 || ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ctrl: got p0=%b p1=%b ack=%b want 0/0/0", p0_req, p1_req, ack); end
      n_run++; if (resp !== SCR1_MEM_RESP_NOTRDY || rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_resp: got %0d/%h want 0/0", resp, rdata); end
      step();
      rst_n = 1'b1;
      step();
      p0_resp = SCR1_MEM_RESP_RDY_OK; p0_rdata = 32'h0000_55AA;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_NOTRDY || rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_stray: got %0d/%h want 0/0", resp, rdata); end
      step();
      p0_resp = SCR1_MEM_RESP_NOTRDY; p0_rdata = '0;
      #1;
      n_run++; if (resp !== SCR1_MEM_RESP_NOTRDY || ack !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got resp=%0d ack=%b want 0/0", resp, ack); end
   endtask

   initial begin
      test_reset();
      test_port0_read();
      step();
      test_port1_write_stall();
      step();
      test_hole();
      step();
      test_ignore_other_port();
      step();
      test_back_to_back();
      step();
      test_reset_mid_wait();
      step();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule : tb_scr1_dmem_port_router
